// File: rtl/pkt_mem_pkg.sv
// Shared definitions for the packet buffer: FSM state codes, bus access widths
// and the default memory depth.
package pkt_mem_pkg;

    typedef enum logic [1:0] {
        PKT_MEM_STATE_IDLE  = 2'd0,
        PKT_MEM_STATE_LOAD  = 2'd1,
        PKT_MEM_STATE_READY = 2'd2,
        PKT_MEM_STATE_DUMP  = 2'd3
    } pkt_mem_state_e;

    localparam logic [3:0] MEM_WIDTH_BYTE = 4'd1;
    localparam logic [3:0] MEM_WIDTH_HALF = 4'd2;
    localparam logic [3:0] MEM_WIDTH_WORD = 4'd4;

    localparam int PKT_MEM_DEPTH = 512;

endpackage

// File: rtl/pkt_mem_lanes.sv
// Big-endian byte-lane decode for the mem bus: byte enables, lane-replicated
// write data and zero-extended read extraction. be[3] is byte offset 0, bits [31:24].
module pkt_mem_lanes
    import pkt_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  width,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        fmt_err
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        be      = 4'b0000;
        wword   = 32'd0;
        rdata   = 32'd0;
        fmt_err = 1'b0;
        case (width)
            MEM_WIDTH_BYTE: begin
                be    = 4'b1000 >> addr_lo;
                wword = {4{wdata[7:0]}};
                rdata = {24'd0, rword[{~addr_lo, 3'b000} +: 8]};
            end
            MEM_WIDTH_HALF: begin
                if (addr_lo[0]) begin
                    fmt_err = 1'b1;
                end else begin
                    be    = addr_lo[1] ? 4'b0011 : 4'b1100;
                    wword = {2{wdata[15:0]}};
                    rdata = {16'd0, (addr_lo[1] ? rword[15:0] : rword[31:16])};
                end
            end
            MEM_WIDTH_WORD: begin
                be    = 4'b1111;
                wword = wdata;
                rdata = rword;
            end
            default: fmt_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/pkt_mem.sv
// Packet buffer: byte-stream ingress/egress plus a shared mem-bus slave port.
// Optional PKT_MEM_BOUNDS_CHECK_EN limits bus accesses to the stored packet in READY/DUMP.
module pkt_mem
    import pkt_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = PKT_MEM_DEPTH,
    parameter int LEN_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_ce_i,
    input  logic             mem_we_i,
    input  logic [31:0]      mem_addr_i,
    input  logic [3:0]       mem_width_i,
    input  logic [31:0]      mem_data_i,
    output logic [31:0]      mem_data_o,
    output logic             mem_err_o,
    input  logic             err_clr_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    input  logic             out_start_i,
    output logic             out_valid_o,
    output logic [7:0]       out_data_o,
    output logic             out_last_o,
    input  logic             out_ready_i,
    output logic             pkt_valid_o,
    output logic [LEN_W-1:0] pkt_len_o
);

    localparam int               CAP   = 4 * DEPTH_WORDS;
    localparam int               AW    = $clog2(DEPTH_WORDS);
    localparam logic [LEN_W-1:0] CAP_L = LEN_W'(CAP);
    localparam logic [31:0]      CAP_A = 32'(CAP);

    logic [31:0] mem [DEPTH_WORDS];

    pkt_mem_state_e   state, next_state;
    logic [LEN_W-1:0] wr_cnt, rd_ptr;
    logic             in_fire, full, in_wr, egress_fire;
    logic [7:0]       eg_byte;
    logic [31:0]      rword, wword, rdata;
    logic [3:0]       be;
    logic             fmt_err, oob, bound_err, bus_err, bus_wr;

    pkt_mem_lanes u_lanes (
        .addr_lo (mem_addr_i[1:0]),
        .width   (mem_width_i),
        .wdata   (mem_data_i),
        .rword   (rword),
        .be      (be),
        .wword   (wword),
        .rdata   (rdata),
        .fmt_err (fmt_err)
    );

    assign rword       = mem[mem_addr_i[AW+1:2]];
    assign eg_byte     = mem[rd_ptr[AW+1:2]][{~rd_ptr[1:0], 3'b000} +: 8];
    assign in_fire     = in_valid_i && in_ready_o;
    assign full        = (wr_cnt == CAP_L);
    assign in_wr       = in_fire && !full;
    assign egress_fire = out_valid_o && out_ready_i;
    assign oob         = (mem_addr_i >= CAP_A);

    always_comb begin
        bound_err = 1'b0;
`ifdef PKT_MEM_BOUNDS_CHECK_EN
        if (state == PKT_MEM_STATE_READY || state == PKT_MEM_STATE_DUMP) begin
            if (mem_width_i == MEM_WIDTH_WORD)
                bound_err = {mem_addr_i[31:2], 2'b00} >= ((32'(pkt_len_o) + 32'd3) & ~32'd3);
            else
                bound_err = mem_addr_i >= 32'(pkt_len_o);
        end
`endif
    end

    // Writes while the stream side owns the array are refused rather than arbitrated.
    assign bus_err = mem_ce_i && (fmt_err || oob || bound_err ||
                     (mem_we_i && (state == PKT_MEM_STATE_LOAD || state == PKT_MEM_STATE_DUMP)));
    assign bus_wr  = mem_ce_i && mem_we_i && !bus_err;

    // NOTE: the array is deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (bus_wr && be[i]) mem[mem_addr_i[AW+1:2]][8*i +: 8] <= wword[8*i +: 8];
        if (in_wr) mem[wr_cnt[AW+1:2]][{~wr_cnt[1:0], 3'b000} +: 8] <= in_data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state <= PKT_MEM_STATE_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            PKT_MEM_STATE_IDLE:  if (in_fire) next_state = in_last_i ? PKT_MEM_STATE_READY : PKT_MEM_STATE_LOAD;
            PKT_MEM_STATE_LOAD:  if (in_fire && in_last_i) next_state = PKT_MEM_STATE_READY;
            PKT_MEM_STATE_READY: if (out_start_i) next_state = PKT_MEM_STATE_DUMP;
            PKT_MEM_STATE_DUMP:  if (egress_fire && out_last_o) next_state = PKT_MEM_STATE_IDLE;
            default:             next_state = PKT_MEM_STATE_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = !rst && (state == PKT_MEM_STATE_IDLE || state == PKT_MEM_STATE_LOAD);
    end

    // out_data_o doubles as the prefetch stage: the next byte is loaded on each accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt      <= '0;
            rd_ptr      <= '0;
            pkt_len_o   <= '0;
            pkt_valid_o <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= 8'd0;
            out_last_o  <= 1'b0;
            mem_err_o   <= 1'b0;
            mem_data_o  <= 32'd0;
        end else begin
            if (mem_ce_i && !mem_we_i) mem_data_o <= bus_err ? 32'd0 : rdata;

            if (bus_err || (in_fire && full)) mem_err_o <= 1'b1;
            else if (err_clr_i)               mem_err_o <= 1'b0;

            case (state)
                PKT_MEM_STATE_IDLE, PKT_MEM_STATE_LOAD: begin
                    if (in_wr) wr_cnt <= wr_cnt + LEN_W'(1);
                    if (in_fire && in_last_i) begin
                        pkt_len_o   <= full ? wr_cnt : wr_cnt + LEN_W'(1);
                        pkt_valid_o <= 1'b1;
                    end
                end
                PKT_MEM_STATE_READY: begin
                    if (out_start_i) begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= eg_byte;
                        out_last_o  <= (pkt_len_o == LEN_W'(1));
                        rd_ptr      <= rd_ptr + LEN_W'(1);
                    end
                end
                PKT_MEM_STATE_DUMP: begin
                    if (egress_fire) begin
                        if (out_last_o) begin
                            out_valid_o <= 1'b0;
                            out_last_o  <= 1'b0;
                            pkt_valid_o <= 1'b0;
                            pkt_len_o   <= '0;
                            wr_cnt      <= '0;
                            rd_ptr      <= '0;
                        end else begin
                            out_data_o <= eg_byte;
                            out_last_o <= (rd_ptr == pkt_len_o - LEN_W'(1));
                            rd_ptr     <= rd_ptr + LEN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_mem.sv
// Scoreboard bench for pkt_mem (DEPTH_WORDS=4, CAP=16): expected bus reads and
// egress bytes are queued by the stimulus and popped by a negedge monitor.
module tb_pkt_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i, mem_we_i;
    logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
    logic [3:0]  mem_width_i;
    logic        mem_err_o, err_clr_i;
    logic        in_valid_i, in_last_i, in_ready_o;
    logic [7:0]  in_data_i, out_data_o;
    logic        out_start_i, out_valid_o, out_last_o, out_ready_i;
    logic        pkt_valid_o;
    logic [15:0] pkt_len_o;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        string       name;
    } rd_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } eg_exp_t;

    rd_exp_t rd_q[$];
    eg_exp_t eg_q[$];
    rd_exp_t rd_cur;
    eg_exp_t eg_cur;
    logic    rd_seen = 1'b0;
    int      n_cmp = 0;
    int      n_fail = 0;

    pkt_mem #(.DEPTH_WORDS(4), .LEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_ce_i    (mem_ce_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_width_i (mem_width_i),
        .mem_data_i  (mem_data_i),
        .mem_data_o  (mem_data_o),
        .mem_err_o   (mem_err_o),
        .err_clr_i   (err_clr_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .out_start_i (out_start_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .pkt_valid_o (pkt_valid_o),
        .pkt_len_o   (pkt_len_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a read issued at one edge is checked at the following negedge.
    always @(posedge clk) rd_seen <= mem_ce_i && !mem_we_i && !rst;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rd_unexpected: got %h, expected no read response", mem_data_o);
            end else begin
                rd_cur = rd_q.pop_front();
                check(rd_cur.name, mem_data_o & rd_cur.mask, rd_cur.data & rd_cur.mask);
            end
        end
        if (out_valid_o && out_ready_i && !rst) begin
            if (eg_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL eg_unexpected: got %h, expected no egress byte", out_data_o);
            end else begin
                eg_cur = eg_q.pop_front();
                check("egress_data", {24'd0, out_data_o}, {24'd0, eg_cur.data});
                check("egress_last", {31'd0, out_last_o}, {31'd0, eg_cur.last});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] e, input logic [31:0] m, input string nm);
        rd_q.push_back('{data: e, mask: m, name: nm});
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = a; mem_width_i = w;
        tick();
        mem_ce_i = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = a; mem_width_i = w; mem_data_i = d;
        tick();
        mem_ce_i = 1'b0; mem_we_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n = 0;
        in_valid_i = 1'b1; in_data_i = d; in_last_i = last;
        while (!in_ready_o && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("in_ready_timeout", {31'd0, in_ready_o}, 32'd1);
        tick();
        in_valid_i = 1'b0; in_last_i = 1'b0;
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
    endtask

    initial begin
        logic [7:0] t1 [6];
        t1 = '{8'h45, 8'h00, 8'h00, 8'h1C, 8'hAB, 8'hCD};
        rst = 1'b1; mem_ce_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_width_i = 0;
        mem_data_i = 0; err_clr_i = 0; in_valid_i = 0; in_data_i = 0; in_last_i = 0;
        out_start_i = 0; out_ready_i = 0;
        repeat (3) tick();
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_pkt_valid", {31'd0, pkt_valid_o}, 32'd0);
        check("rst_pkt_len", {16'd0, pkt_len_o}, 32'd0);
        check("rst_mem_err", {31'd0, mem_err_o}, 32'd0);
        check("rst_mem_data", mem_data_o, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready_o}, 32'd1);

        out_start_i = 1'b1;
        tick();
        out_start_i = 1'b0;
        tick();
        check("idle_start_ignored", {31'd0, out_valid_o}, 32'd0);

        // 1: load 6 bytes
        for (int i = 0; i < 6; i++) send_byte(t1[i], i == 5);
        check("t1_pkt_valid", {31'd0, pkt_valid_o}, 32'd1);
        check("t1_pkt_len", {16'd0, pkt_len_o}, 32'd6);
        check("t1_in_ready_stall", {31'd0, in_ready_o}, 32'd0);
        bus_rd(32'd0, 4'd4, 32'h4500001C, 32'hFFFFFFFF, "t1_rd_w4_0");

        // 2: halfword, covering word, misaligned and bad-width reads
        bus_rd(32'd4, 4'd2, 32'h0000ABCD, 32'hFFFFFFFF, "t2_rd_w2_4");
        bus_rd(32'd6, 4'd4, 32'hABCD0000, 32'hFFFF0000, "t2_rd_w4_6");
        bus_rd(32'd3, 4'd2, 32'h00000000, 32'hFFFFFFFF, "t2_rd_w2_3");
        check("t2_err_misalign", {31'd0, mem_err_o}, 32'd1);
        clear_err();
        check("t2_err_clr", {31'd0, mem_err_o}, 32'd0);
        bus_rd(32'd0, 4'd3, 32'h00000000, 32'hFFFFFFFF, "t2_rd_w3");
        check("t2_err_width", {31'd0, mem_err_o}, 32'd1);
        clear_err();

        // 3: halfword write in READY
        bus_wr(32'd2, 4'd2, 32'h00001234);
        check("t3_wr_no_err", {31'd0, mem_err_o}, 32'd0);
        bus_rd(32'd0, 4'd4, 32'h45001234, 32'hFFFFFFFF, "t3_rd_w4_0");
        bus_rd(32'd1, 4'd1, 32'h00000000, 32'hFFFFFFFF, "t3_rd_w1_1");

        // 4: drain with out_ready pattern 1,0,1
        eg_q.push_back('{8'h45, 1'b0}); eg_q.push_back('{8'h00, 1'b0});
        eg_q.push_back('{8'h12, 1'b0}); eg_q.push_back('{8'h34, 1'b0});
        eg_q.push_back('{8'hAB, 1'b0}); eg_q.push_back('{8'hCD, 1'b1});
        out_start_i = 1'b1;
        tick();
        out_start_i = 1'b0;
        check("t4_valid_after_start", {31'd0, out_valid_o}, 32'd1);
        for (int i = 0; i < 40 && eg_q.size() > 0; i++) begin
            out_ready_i = (i % 3 != 1);
            tick();
        end
        out_ready_i = 1'b0;
        check("t4_drain_left", eg_q.size(), 32'd0);
        check("t4_pkt_valid", {31'd0, pkt_valid_o}, 32'd0);
        check("t4_pkt_len", {16'd0, pkt_len_o}, 32'd0);
        check("t4_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("t4_out_valid", {31'd0, out_valid_o}, 32'd0);

        // 5: overflow, 19 bytes into a 16-byte buffer
        for (int i = 0; i < 19; i++) send_byte(8'h10 + 8'(i), i == 18);
        check("t5_pkt_len_sat", {16'd0, pkt_len_o}, 32'd16);
        check("t5_err_overflow", {31'd0, mem_err_o}, 32'd1);
        bus_rd(32'd0, 4'd4, 32'h10111213, 32'hFFFFFFFF, "t5_rd_w4_0");
        bus_rd(32'd12, 4'd4, 32'h1C1D1E1F, 32'hFFFFFFFF, "t5_rd_w4_12");
        bus_rd(32'd16, 4'd1, 32'h00000000, 32'hFFFFFFFF, "t5_rd_oob");

        // 6: reset after two bytes of the drain
        eg_q.push_back('{8'h10, 1'b0}); eg_q.push_back('{8'h11, 1'b0});
        out_start_i = 1'b1; out_ready_i = 1'b1;
        tick();
        out_start_i = 1'b0;
        check("t6_valid_after_start", {31'd0, out_valid_o}, 32'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t6_in_ready_in_rst", {31'd0, in_ready_o}, 32'd0);
        #1;
        tick();
        rst = 1'b0; out_ready_i = 1'b0;
        check("t6_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("t6_pkt_valid", {31'd0, pkt_valid_o}, 32'd0);
        check("t6_pkt_len", {16'd0, pkt_len_o}, 32'd0);
        check("t6_err_rst", {31'd0, mem_err_o}, 32'd0);
        check("t6_drain_left", eg_q.size(), 32'd0);
        #1;
        check("t6_in_ready_idle", {31'd0, in_ready_o}, 32'd1);
        send_byte(8'hA1, 1'b0);
        bus_wr(32'd2, 4'd1, 32'h000000EE);
        check("t6_err_wr_in_load", {31'd0, mem_err_o}, 32'd1);
        send_byte(8'hB2, 1'b1);
        check("t6_pkt_len_new", {16'd0, pkt_len_o}, 32'd2);
        bus_rd(32'd0, 4'd2, 32'h0000A1B2, 32'hFFFFFFFF, "t6_rd_w2_0");
        bus_rd(32'd2, 4'd1, 32'h00000012, 32'hFFFFFFFF, "t6_rd_blocked_wr");

        tick();
        tick();
        check("rd_q_empty", rd_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pkt_mem.md
Name: pkt_mem

Overview:
- Packet buffer memory that answers the shared mem bus (ce/we/addr/width/data) driven by processing blocks such as the checksum engine.
- Its ingress byte-stream port loads a packet from address 0.
- Its egress byte-stream port drains the packet after processing.
- Byte-addressed, big-endian (byte 0 of a word is bits [31:24]), one-cycle read latency.

Parameters:
DEPTH_WORDS, 512, number of 32-bit words; capacity CAP = 4*DEPTH_WORDS bytes
LEN_W, 16, width of packet length counter (must hold CAP)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_ce_i  in  1  bus access enable
mem_we_i  in  1  1=write, 0=read
mem_addr_i  in  32  byte address
mem_width_i  in  4  access width in bytes: 1, 2 or 4
mem_data_i  in  32  write data, right-justified
mem_data_o  out  32  read data, valid the cycle after the request
mem_err_o  out  1  sticky access-error flag
err_clr_i  in  1  clears mem_err_o
in_valid_i  in  1  ingress byte valid
in_data_i  in  8  ingress byte
in_last_i  in  1  final byte of packet
in_ready_o  out  1  ingress accept
out_start_i  in  1  request drain of stored packet
out_valid_o  out  1  egress byte valid
out_data_o  out  8  egress byte
out_last_o  out  1  final egress byte
out_ready_i  in  1  egress accept
pkt_valid_o  out  1  a complete packet is stored
pkt_len_o  out  LEN_W  stored packet length in bytes

Behaviour:
- Reset: all outputs 0, state IDLE, byte counters 0, pkt_len_o 0. Array contents are not cleared. Reset mid-load or mid-drain abandons the packet immediately.
- States: IDLE, LOAD, READY, DUMP.
- in_ready_o = 1 in IDLE and LOAD, otherwise 0; forced 0 while rst.
- IDLE: an accepted byte is written to address 0, next state LOAD (or READY if in_last_i).
- LOAD: each accepted byte is written at the write counter, then the counter increments.
  - in_last_i accepted -> READY, pkt_valid_o=1, pkt_len_o = byte count including the last byte.
  - Bytes beyond CAP are dropped and set mem_err_o; pkt_len_o saturates at CAP.
- READY: out_start_i -> DUMP.
  - out_start_i in any other state is ignored.
  - Ingress is stalled.
- DUMP: out_valid_o rises 1 cycle after out_start_i with byte 0.
  - Bytes 0..pkt_len-1 are presented in order.
  - Holds data while out_ready_i=0.
  - Sustains 1 byte/cycle while out_ready_i=1; a prefetch register is required.
  - out_last_o accompanies byte pkt_len-1.
  - When the last byte is accepted: -> IDLE, pkt_valid_o=0, pkt_len_o=0.
- Mem-bus reads (ce=1, we=0), served in all states; mem_data_o is updated the next cycle:
  - width 4: aligned word containing addr; addr[1:0] is ignored.
  - width 2: halfword at addr, zero-extended into [15:0]; addr[0] must be 0.
  - width 1: byte in [7:0].
  - When ce=0, mem_data_o holds its last value.
- Mem-bus writes:
  - width 4 writes the aligned word.
  - width 2 writes bytes addr and addr+1 from [15:0].
  - width 1 writes [7:0].
  - Bytes not covered by the width are untouched.
- Errors: each of the following ignores the write, returns 0 on a read, and sets mem_err_o:
  - misaligned halfword access;
  - width not in {1,2,4};
  - addr >= CAP;
  - a mem-bus write while in LOAD or DUMP.
- Simultaneous events:
  - A mem-bus write and an ingress write to the same byte in one cycle cannot occur, because bus writes are blocked in LOAD.
  - A read-after-write to the same address returns the new data on the next access.
  - err_clr_i together with a new error: the error wins.

Optional Feature:
PKT_MEM_BOUNDS_CHECK_EN
- Defined: in READY/DUMP, bus accesses with addr >= pkt_len_o (rounded up to the covering word for width 4) are also errors; the write is ignored, a read returns 0, and mem_err_o is set.
- Undefined: only addr >= CAP is checked.

Decomposition:
- Shared def.vh gains:
  - PKT_MEM_STATE_IDLE/LOAD/READY/DUMP codes;
  - MEM_WIDTH_BYTE/HALF/WORD constants (1/2/4);
  - PKT_MEM_DEPTH default.
- One sub-module, pkt_mem_lanes: combinational decode of addr/width/data into per-byte write enables, lane-shifted write data, and read-data extraction/zero-extension.

Test Plan:
1. Load 6 bytes 45 00 00 1C AB CD with last on CD -> pkt_valid_o=1, pkt_len_o=6; read width 4 @0 -> 0x4500001C next cycle.
2. Read width 2 @4 -> 0x0000ABCD; read width 4 @6 -> word 1 (0xABCDxxxx); read width 2 @3 -> 0 and mem_err_o=1; err_clr_i -> 0.
3. Write width 2 data 0x1234 @2, then read width 4 @0 -> 0x45001234; byte @1 -> 0x00.
4. out_start_i with out_ready_i toggling 1,0,1 -> bytes 45 00 12 34 AB CD in order, out_last_o only on CD; afterwards pkt_valid_o=0, in_ready_o=1.
5. Load CAP+3 bytes with DEPTH_WORDS=4 -> pkt_len_o=16, mem_err_o=1; bytes 16..18 are not written.
6. Assert rst during DUMP after 2 bytes -> next cycle out_valid_o=0, pkt_valid_o=0, state IDLE; a new load starts at address 0.
